my_dmux4way16_buf: RTL and testbench

//  Buffered 1-to-4 demultiplexer, the inverse of the 4-way 16-bit mux.

---
 rtl/my_dmux_defs.sv | 23 ++
 rtl/my_dmux_slot.sv | 60 ++++++
 rtl/my_dmux4way16_buf.sv | 88 ++++++++
 tb/tb_my_dmux4way16_buf.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_dmux_defs.sv
// Shared definitions for the buffered 1-to-4 demultiplexer: channel count,
// select width, channel codes and the select decoder.
package my_dmux_defs;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [SEL_W-1:0] {
        CH_A = 2'b00,
        CH_B = 2'b01,
        CH_C = 2'b10,
        CH_D = 2'b11
    } ch_e;

    // One-hot decode of a channel select code.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] code);
        logic [NUM_CH-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/my_dmux_slot.sv
// One output channel of the demultiplexer: a single-entry holding register
// with valid/ready handshake and a wrapping count of accepted words.
module my_dmux_slot #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: drain on consumer handshake, then a load overrides it so a
    // same-edge drain and refill keeps the slot full (1 word/cycle).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            data_d  = data;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State register with synchronous reset; data keeps its value after a drain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: the data register is reset as well because out is visible
            // and must read zero after reset, not a stale discarded word.
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out   = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/my_dmux4way16_buf.sv
// Buffered 1-to-4 demultiplexer: routes one word per accepted handshake to
// channel a/b/c/d selected by sel; each channel buffers one word and drains
// independently through its own valid/ready handshake.
module my_dmux4way16_buf
    import my_dmux_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             valid_a,
    output logic             valid_b,
    output logic             valid_c,
    output logic             valid_d,
    input  logic             ready_a,
    input  logic             ready_b,
    input  logic             ready_c,
    input  logic             ready_d,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    logic [WIDTH-1:0]  out_arr [NUM_CH];
    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    logic [NUM_CH-1:0] valid_vec;
    logic [NUM_CH-1:0] ready_vec;
    logic [NUM_CH-1:0] load_vec;
    logic              accept;

    assign ready_vec = {ready_d, ready_c, ready_b, ready_a};

    // in_ready depends only on the selected channel: its slot is empty or
    // is being drained this cycle. in_valid plays no part.
    always_comb begin
        in_ready = 1'b0;
        unique case (sel)
            CH_A: in_ready = !valid_vec[CH_A] || ready_vec[CH_A];
            CH_B: in_ready = !valid_vec[CH_B] || ready_vec[CH_B];
            CH_C: in_ready = !valid_vec[CH_C] || ready_vec[CH_C];
            CH_D: in_ready = !valid_vec[CH_D] || ready_vec[CH_D];
            default: in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign load_vec = accept ? sel_decode(sel) : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        my_dmux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk  (clk),
            .reset(reset),
            .load (load_vec[i]),
            .data (in),
            .ready(ready_vec[i]),
            .out  (out_arr[i]),
            .valid(valid_vec[i]),
            .cnt  (cnt_arr[i])
        );
    end

    assign out_a   = out_arr[CH_A];
    assign out_b   = out_arr[CH_B];
    assign out_c   = out_arr[CH_C];
    assign out_d   = out_arr[CH_D];
    assign valid_a = valid_vec[CH_A];
    assign valid_b = valid_vec[CH_B];
    assign valid_c = valid_vec[CH_C];
    assign valid_d = valid_vec[CH_D];
    assign cnt_a   = cnt_arr[CH_A];
    assign cnt_b   = cnt_arr[CH_B];
    assign cnt_c   = cnt_arr[CH_C];
    assign cnt_d   = cnt_arr[CH_D];

endmodule

// File: tb/tb_my_dmux4way16_buf.sv
// Self-checking bench for my_dmux4way16_buf: directed scenarios plus a
// randomized run, all compared against a queue-based channel model.
module tb_my_dmux4way16_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_w;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rdy;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;

    logic [15:0] obs_out [4];
    logic [7:0]  obs_cnt [4];
    logic [3:0]  obs_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a FIFO of capacity one, plus the
    // last word shown on its output and a count of accepted words.
    logic [15:0] m_q [4][$];
    logic [15:0] m_out [4];
    int          m_cnt [4];

    always #5 clk = ~clk;

    my_dmux4way16_buf dut (
        .clk(clk), .reset(reset), .in(in_w), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
        .ready_a(rdy[0]), .ready_b(rdy[1]), .ready_c(rdy[2]), .ready_d(rdy[3]),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
    );

    assign obs_out[0] = out_a;
    assign obs_out[1] = out_b;
    assign obs_out[2] = out_c;
    assign obs_out[3] = out_d;
    assign obs_cnt[0] = cnt_a;
    assign obs_cnt[1] = cnt_b;
    assign obs_cnt[2] = cnt_c;
    assign obs_cnt[3] = cnt_d;
    assign obs_valid  = {valid_d, valid_c, valid_b, valid_a};

    function automatic bit m_can_take(input logic [1:0] s);
        return (m_q[s].size() == 0) || (rdy[s] == 1'b1);
    endfunction

    // Advance one clock edge and update the model with the inputs as driven.
    task automatic tick();
        bit acc;
        acc = in_valid && m_can_take(sel);
        @(posedge clk);
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_q[c].delete();
                m_out[c] = '0;
                m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++)
                if (m_q[c].size() != 0 && rdy[c]) void'(m_q[c].pop_front());
            if (acc) begin
                m_q[sel].push_back(in_w);
                m_out[sel] = in_w;
                m_cnt[sel] = (m_cnt[sel] + 1) % 256;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_w = '0; sel = 2'b00; rdy = 4'h0;
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_valid[c] !== 1'b0) begin
                errors++; $display("FAIL reset_valid ch%0d got %b want 0", c, obs_valid[c]);
            end
            checks++;
            if (obs_out[c] !== 16'h0000) begin
                errors++; $display("FAIL reset_out ch%0d got %h want 0000", c, obs_out[c]);
            end
            checks++;
            if (obs_cnt[c] !== 8'd0) begin
                errors++; $display("FAIL reset_cnt ch%0d got %0d want 0", c, obs_cnt[c]);
            end
            sel = 2'(c);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready sel%0d got %b want 1", c, in_ready);
            end
        end
    endtask

    task automatic test_routing();
        logic [15:0] words [4];
        words[0] = 16'h5555; words[1] = 16'hAAAA; words[2] = 16'h00FF; words[3] = 16'hFF00;
        rdy = 4'hF;
        for (int c = 0; c < 4; c++) begin
            sel = 2'(c); in_w = words[c]; in_valid = 1'b1;
            tick();
            checks++;
            if (obs_out[c] !== words[c] || obs_valid[c] !== 1'b1) begin
                errors++;
                $display("FAIL routing ch%0d got %h/v%b want %h/v1", c, obs_out[c], obs_valid[c], words[c]);
            end
        end
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_cnt[c] !== 8'd1 || obs_valid[c] !== 1'b0 || obs_out[c] !== words[c]) begin
                errors++;
                $display("FAIL routing_after ch%0d got cnt%0d/v%b/%h want cnt1/v0/%h",
                         c, obs_cnt[c], obs_valid[c], obs_out[c], words[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        rdy = 4'hF; rdy[1] = 1'b0;
        sel = 2'b01; in_w = 16'hAAAA; in_valid = 1'b1;
        tick();
        in_w = 16'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_low got %b want 0", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_b !== 16'hAAAA || valid_b !== 1'b1 || cnt_b !== 8'd2) begin
                errors++;
                $display("FAIL bp_hold got %h/v%b/cnt%0d want aaaa/v1/cnt2", out_b, valid_b, cnt_b);
            end
        end
        rdy[1] = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_in_ready_high got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_b !== 16'h1234 || valid_b !== 1'b1 || cnt_b !== 8'd3) begin
            errors++;
            $display("FAIL bp_release got %h/v%b/cnt%0d want 1234/v1/cnt3", out_b, valid_b, cnt_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int start;
        start = m_cnt[2];
        rdy[2] = 1'b1; sel = 2'b10; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 16'(16'hC000 + k * 16'h0111);
            in_w = w;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready word%0d got %b want 1", k, in_ready);
            end
            tick();
            checks++;
            if (out_c !== w || valid_c !== 1'b1) begin
                errors++; $display("FAIL b2b_word%0d got %h/v%b want %h/v1", k, out_c, valid_c, w);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (valid_c !== 1'b0 || cnt_c !== 8'(start + 4)) begin
            errors++;
            $display("FAIL b2b_end got v%b/cnt%0d want v0/cnt%0d", valid_c, cnt_c, start + 4);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        rdy = 4'hF; sel = 2'b11; in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in_w = 16'($urandom);
            tick();
            if (k == 254) begin
                checks++;
                if (cnt_d !== 8'd255) begin
                    errors++; $display("FAIL wrap_255 got %0d want 255", cnt_d);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (cnt_d !== 8'd0) begin
            errors++; $display("FAIL wrap_zero got %0d want 0", cnt_d);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rdy = 4'hF; rdy[0] = 1'b0;
        sel = 2'b00; in_w = 16'hBEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (valid_a !== 1'b1 || out_a !== 16'hBEEF) begin
            errors++; $display("FAIL rmid_load got %h/v%b want beef/v1", out_a, valid_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdy[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid_a !== 1'b0 || cnt_a !== 8'd0 || out_a !== 16'h0000) begin
                errors++;
                $display("FAIL rmid_after cyc%0d got %h/v%b/cnt%0d want 0000/v0/cnt0", k, out_a, valid_a, cnt_a);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                sel      = 2'($urandom_range(0, 3));
                in_w     = 16'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            rdy = 4'($urandom);
            #1;
            checks++;
            if (in_ready !== m_can_take(sel)) begin
                errors++; $display("FAIL rand_in_ready cyc%0d got %b want %b", n, in_ready, m_can_take(sel));
            end
            hold = in_valid && !m_can_take(sel);
            tick();
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (obs_valid[c] !== (m_q[c].size() != 0) || obs_out[c] !== m_out[c] ||
                    obs_cnt[c] !== 8'(m_cnt[c])) begin
                    errors++;
                    $display("FAIL rand_state cyc%0d ch%0d got %h/v%b/cnt%0d want %h/v%b/cnt%0d",
                             n, c, obs_out[c], obs_valid[c], obs_cnt[c],
                             m_out[c], (m_q[c].size() != 0), m_cnt[c]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            m_out[c] = '0;
            m_cnt[c] = 0;
        end
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
